// File: rtl/split_eval_seq_if.sv
// rtl/split_eval_seq_if.sv - variable-stream and verdict bundle for split_eval_seq
//
// Purpose: groups the start/configuration, variable beat stream and verdict
// signals of split_eval_seq into one bundle.
// Signals:
//   start, mode[1:0], bound[MAX_W]     evaluation start and constraint config
//   in_valid, in_ready                 beat handshake
//   in_idx[IDX_W], in_width[WID_W],    beat payload
//   in_data[MAX_W]
//   busy, x_valid, x, err              status and verdict
// Modports: master drives config and beats, slave is the evaluator.
interface split_eval_seq_if #(
  parameter int MAX_W = 16,
  parameter int IDX_W = 8,
  parameter int WID_W = 5
);
  logic             start;
  logic [1:0]       mode;
  logic [MAX_W-1:0] bound;
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_idx;
  logic [WID_W-1:0] in_width;
  logic [MAX_W-1:0] in_data;
  logic             busy;
  logic             x_valid;
  logic             x;
  logic             err;

  modport master (
    output start, mode, bound, in_valid, in_idx, in_width, in_data,
    input  in_ready, busy, x_valid, x, err
  );

  modport slave (
    input  start, mode, bound, in_valid, in_idx, in_width, in_data,
    output in_ready, busy, x_valid, x, err
  );
endinterface

// File: rtl/split_eval_seq.sv
// rtl/split_eval_seq.sv - sequential split constraint evaluator with verdict output
//
// Purpose: accepts NUM_VARS variables one per beat, evaluates the constraint
// chosen at start (CONST, NONZERO, PARITY, LE_BOUND) and reports a verdict
// bit x with a level x_valid, plus a sticky protocol error flag.
// Ports:
//   i_clk   rising-edge clock
//   i_rst   synchronous active-high reset
//   io_bus  split_eval_seq_if.slave: start/mode/bound, beat stream
//           (in_valid/in_ready/in_idx/in_width/in_data), busy/x_valid/x/err
module split_eval_seq #(
  parameter int NUM_VARS = 150,
  parameter int MAX_W    = 16,
  parameter int IDX_W    = 8,
  parameter int WID_W    = 5
) (
  input  logic           i_clk,
  input  logic           i_rst,
  split_eval_seq_if.slave io_bus
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_VARS - 1);
  localparam logic [WID_W-1:0] MAX_WIDTH = WID_W'(MAX_W);

  localparam logic [1:0] MODE_CONST   = 2'd0;
  localparam logic [1:0] MODE_NONZERO = 2'd1;
  localparam logic [1:0] MODE_PARITY  = 2'd2;
  localparam logic [1:0] MODE_LE      = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_cnt;
  logic [1:0]       r_mode;
  logic [MAX_W-1:0] r_bound;
  logic             r_acc;
  logic             r_err;
  logic             r_x;

  logic             w_ready;
  logic             w_accept;
  logic             w_last;
  logic [MAX_W-1:0] w_masked;
  logic             w_beat_err;
  logic             w_acc_next;
  logic             w_err_next;

  // Bit i survives only when i < in_width; identical to AND-ing with
  // (1<<in_width)-1 evaluated one bit wider than MAX_W, so width MAX_W keeps
  // every bit and oversize widths (flagged as errors) keep every bit too.
  always_comb begin
    w_masked = '0;
    for (int i = 0; i < MAX_W; i++) begin
      w_masked[i] = io_bus.in_data[i] & (i < int'(io_bus.in_width));
    end
  end

  // A start pulse in COLLECT wins over a beat offered in the same cycle.
  assign w_ready  = (r_state == S_COLLECT) && !io_bus.start;
  assign w_accept = w_ready && io_bus.in_valid;
  assign w_last   = (r_cnt == LAST_IDX);

  assign w_beat_err = (io_bus.in_idx != r_cnt)
                   || (io_bus.in_width == '0)
                   || (io_bus.in_width > MAX_WIDTH);
  assign w_err_next = r_err || w_beat_err;

  always_comb begin
    w_acc_next = r_acc;
    case (r_mode)
      MODE_CONST:   w_acc_next = r_acc;
      MODE_NONZERO: w_acc_next = r_acc & (|w_masked);
      MODE_PARITY:  w_acc_next = r_acc ^ (^w_masked);
      MODE_LE:      w_acc_next = r_acc & (w_masked <= r_bound);
      default:      w_acc_next = r_acc;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (io_bus.start) w_state_next = S_COLLECT;
      end
      S_COLLECT: begin
        if (io_bus.start) begin
          w_state_next = S_COLLECT;
        end else if (w_accept && w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (io_bus.start) w_state_next = S_COLLECT;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_mode  <= MODE_CONST;
      r_bound <= '0;
      r_acc   <= 1'b0;
      r_err   <= 1'b0;
      r_x     <= 1'b0;
    end else if (io_bus.start) begin
      r_cnt   <= '0;
      r_mode  <= io_bus.mode;
      r_bound <= io_bus.bound;
      // PARITY folds bits with XOR so it starts from 0; the others AND.
      r_acc   <= (io_bus.mode != MODE_PARITY);
      r_err   <= 1'b0;
      r_x     <= 1'b0;
    end else if (w_accept) begin
      // The counter parks on the last index; leaving COLLECT stops counting.
      if (!w_last) r_cnt <= r_cnt + 1'b1;
      r_acc <= w_acc_next;
      r_err <= w_err_next;
      if (w_last) r_x <= w_acc_next && !w_err_next;
    end
  end

  assign io_bus.in_ready = w_ready;
  assign io_bus.busy     = (r_state == S_COLLECT);
  assign io_bus.x_valid  = (r_state == S_DONE);
  assign io_bus.x        = r_x;
  assign io_bus.err      = r_err;

endmodule

// File: tb/tb_split_eval_seq.sv
// tb/tb_split_eval_seq.sv - self-checking bench for split_eval_seq
module tb_split_eval_seq;
  localparam int NV = 4;
  localparam int MW = 8;
  localparam int IW = 2;
  localparam int WW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  split_eval_seq_if #(.MAX_W(MW), .IDX_W(IW), .WID_W(WW)) bus ();

  split_eval_seq #(.NUM_VARS(NV), .MAX_W(MW), .IDX_W(IW), .WID_W(WW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus)
  );

  int total = 0;
  int bad   = 0;

  int b_idx[NV];
  int b_w[NV];
  int b_d[NV];

  logic o_x, o_err, o_xv, o_pre_xv;
  bit   o_to;

  // Reference: verdict straight from the constraint rules over the beat list.
  function automatic logic [1:0] model(input int mode, input int bound);
    bit e   = 1'b0;
    bit acc = (mode != 2);
    int m;
    for (int i = 0; i < NV; i++) begin
      if (b_idx[i] != i || b_w[i] == 0 || b_w[i] > MW) e = 1'b1;
      m = b_d[i] & ((1 << b_w[i]) - 1);
      case (mode)
        1: if (m == 0) acc = 1'b0;
        2: acc = acc ^ ($countones(m) % 2 == 1);
        3: if (m > bound) acc = 1'b0;
        default: ;
      endcase
    end
    return {acc && !e, e};
  endfunction

  task automatic set_beats(input int d0, d1, d2, d3, input int w0, w1, w2, w3);
    b_d[0] = d0; b_d[1] = d1; b_d[2] = d2; b_d[3] = d3;
    b_w[0] = w0; b_w[1] = w1; b_w[2] = w2; b_w[3] = w3;
    for (int i = 0; i < NV; i++) b_idx[i] = i;
  endtask

  task automatic pulse_start(input int mode, input int bound);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = mode[1:0];
    bus.bound = bound[MW-1:0];
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic send_beat(input int idx, input int w, input int d);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_idx   = idx[IW-1:0];
    bus.in_width = w[WW-1:0];
    bus.in_data  = d[MW-1:0];
    #1;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!bus.in_ready) o_to = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_eval(input int mode, input int bound, input int gap, input bit rgap);
    int g;
    o_to = 1'b0;
    pulse_start(mode, bound);
    for (int i = 0; i < NV; i++) begin
      g = rgap ? int'($urandom_range(0, 3)) : gap;
      for (int k = 0; k < g; k++) @(negedge clk);
      if (i == NV - 1) o_pre_xv = bus.x_valid;
      send_beat(b_idx[i], b_w[i], b_d[i]);
    end
    #1;
    o_xv  = bus.x_valid;
    o_x   = bus.x;
    o_err = bus.err;
  endtask

  task automatic test_reset();
    logic [4:0] got;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    got = {bus.busy, bus.x_valid, bus.x, bus.err, bus.in_ready};
    total++;
    if (got !== 5'b0) begin
      bad++;
      $display("FAIL reset_state: busy/xv/x/err/rdy=%b want 00000", got);
    end
  endtask

  task automatic test_const();
    logic [1:0] exp;
    set_beats(0, 0, 0, 0, 8, 8, 8, 8);
    b_idx[1] = 3;
    exp = model(0, 0);
    run_eval(0, 0, 0, 1'b0);
    total++;
    if ({o_to, o_pre_xv, o_xv, o_x, o_err} !== {3'b001, exp}) begin
      bad++;
      $display("FAIL const_bad_idx: to/prexv/xv/x/err=%b%b%b%b%b want 001%b", o_to, o_pre_xv, o_xv, o_x, o_err, exp);
    end
    b_idx[1] = 1;
    exp = model(0, 0);
    run_eval(0, 0, 0, 1'b0);
    total++;
    if ({o_to, o_pre_xv, o_xv, o_x, o_err} !== {3'b001, exp}) begin
      bad++;
      $display("FAIL const_ok: to/prexv/xv/x/err=%b%b%b%b%b want 001%b", o_to, o_pre_xv, o_xv, o_x, o_err, exp);
    end
  endtask

  task automatic test_nonzero();
    logic [1:0] exp;
    for (int r = 0; r < 2; r++) begin
      set_beats('h01, 'h10, 'h80, 'h03, 1, (r == 0) ? 5 : 4, 8, 2);
      exp = model(1, 0);
      run_eval(1, 0, 0, 1'b0);
      total++;
      if ({o_to, o_pre_xv, o_xv, o_x, o_err} !== {3'b001, exp}) begin
        bad++;
        $display("FAIL nonzero_mask_%0d: to/prexv/xv/x/err=%b%b%b%b%b want 001%b", r, o_to, o_pre_xv, o_xv, o_x, o_err, exp);
      end
    end
  endtask

  task automatic test_parity();
    logic [1:0] exp;
    for (int r = 0; r < 4; r++) begin
      set_beats('h07, (r % 2 == 0) ? 'h01 : 'h03, 'h00, 'hFF, 8, 8, 8, 8);
      exp = model(2, 0);
      run_eval(2, 0, (r >= 2) ? 3 : 0, 1'b0);
      total++;
      if ({o_to, o_pre_xv, o_xv, o_x, o_err} !== {3'b001, exp}) begin
        bad++;
        $display("FAIL parity_%0d: to/prexv/xv/x/err=%b%b%b%b%b want 001%b", r, o_to, o_pre_xv, o_xv, o_x, o_err, exp);
      end
    end
  endtask

  task automatic test_le_bound();
    logic [1:0] exp;
    for (int r = 0; r < 3; r++) begin
      set_beats('h40, 'h00, (r == 1) ? 'h41 : 'h3F, 'h40, (r == 2) ? 0 : 8, 8, 8, 8);
      exp = model(3, 'h40);
      run_eval(3, 'h40, 0, 1'b0);
      total++;
      if ({o_to, o_pre_xv, o_xv, o_x, o_err} !== {3'b001, exp}) begin
        bad++;
        $display("FAIL le_bound_%0d: to/prexv/xv/x/err=%b%b%b%b%b want 001%b", r, o_to, o_pre_xv, o_xv, o_x, o_err, exp);
      end
    end
  endtask

  task automatic test_restart();
    logic [2:0] got;
    o_to = 1'b0;
    pulse_start(1, 0);
    send_beat(0, 8, 1);
    send_beat(1, 8, 1);
    bus.start    = 1'b1;
    bus.mode     = 2'd1;
    bus.in_valid = 1'b1;
    bus.in_idx   = 2'd2;
    bus.in_width = 4'd8;
    bus.in_data  = 8'h01;
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL restart_ready: in_ready=%b want 0", bus.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < NV - 1; i++) send_beat(i, 8, 1);
    #1;
    got = {o_to, bus.busy, bus.x_valid};
    total++;
    if (got !== 3'b010) begin
      bad++;
      $display("FAIL restart_3beats: to/busy/xv=%b want 010", got);
    end
    send_beat(NV - 1, 8, 1);
    #1;
    got = {bus.x_valid, bus.x, bus.err};
    total++;
    if (got !== 3'b110) begin
      bad++;
      $display("FAIL restart_done: xv/x/err=%b want 110", got);
    end
    // reset in the middle of an evaluation
    pulse_start(2, 0);
    send_beat(0, 8, 3);
    send_beat(1, 0, 3);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.x_valid, bus.x, bus.err, bus.in_ready} !== 5'b0) begin
      bad++;
      $display("FAIL reset_mid: busy/xv/x/err/rdy=%b want 00000", {bus.busy, bus.x_valid, bus.x, bus.err, bus.in_ready});
    end
  endtask

  task automatic test_post_done();
    logic [2:0] got;
    set_beats(1, 2, 3, 4, 8, 8, 8, 8);
    run_eval(0, 0, 0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      bus.in_valid = 1'b1;
      bus.in_idx   = 2'd0;
      bus.in_width = 4'd8;
      #1;
      got = {bus.in_ready, bus.x_valid, bus.x};
      total++;
      if (got !== 3'b011) begin
        bad++;
        $display("FAIL done_hold_%0d: rdy/xv/x=%b want 011", c, got);
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    got = {bus.in_ready, bus.busy, bus.x_valid};
    total++;
    if (got !== 3'b000) begin
      bad++;
      $display("FAIL idle_beats: rdy/busy/xv=%b want 000", got);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [1:0] exp;
    int mode, bound;
    for (int r = 0; r < 24; r++) begin
      mode  = int'($urandom_range(0, 3));
      bound = int'($urandom_range(0, 255));
      for (int i = 0; i < NV; i++) begin
        b_idx[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : i;
        if ($urandom_range(0, 9) == 0) b_w[i] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(9, 15));
        else b_w[i] = int'($urandom_range(1, 8));
        b_d[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
      end
      exp = model(mode, bound);
      run_eval(mode, bound, 0, 1'b1);
      total++;
      if ({o_to, o_pre_xv, o_xv, o_x, o_err} !== {3'b001, exp}) begin
        bad++;
        $display("FAIL random_%0d mode=%0d: to/prexv/xv/x/err=%b%b%b%b%b want 001%b", r, mode, o_to, o_pre_xv, o_xv, o_x, o_err, exp);
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.mode     = 2'd0;
    bus.bound    = '0;
    bus.in_valid = 1'b0;
    bus.in_idx   = '0;
    bus.in_width = '0;
    bus.in_data  = '0;
    test_reset();
    test_const();
    test_nonzero();
    test_parity();
    test_le_bound();
    test_restart();
    test_post_done();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/split_eval_seq.md
Name: split_eval_seq

Overview:
- Sequential, parametrised successor to the constant-verdict split blocks.
- Instead of taking all variables in parallel and tying the verdict to 1, it accepts the split's variables one per beat over a valid/ready stream.
- Evaluates a run-time selectable constraint over them and reports a single verdict bit `x` with a done/valid indication.
- Sits between the variable-stream source and the solver's result collector.

Parameters:
- NUM_VARS, 150: number of variables per evaluation.
- MAX_W, 16: maximum variable width in bits; in_data width.
- IDX_W, 8: width of the variable index; must satisfy 2^IDX_W >= NUM_VARS.
- WID_W, 5: width of the in_width field; must hold MAX_W.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins (or restarts) an evaluation.
- mode  input  2  constraint select, sampled on start: 0 CONST, 1 NONZERO, 2 PARITY, 3 LE_BOUND.
- bound  input  MAX_W  upper bound for LE_BOUND, sampled on start.
- in_valid  input  1  variable beat valid.
- in_ready  output  1  block accepts a beat.
- in_idx  input  IDX_W  index of the variable in this beat.
- in_width  input  WID_W  declared width of the variable, 1..MAX_W.
- in_data  input  MAX_W  variable value, LSB-aligned; bits at or above in_width are ignored.
- busy  output  1  evaluation in progress.
- x_valid  output  1  verdict valid; level, held until next start or reset.
- x  output  1  verdict.
- err  output  1  protocol error seen in current evaluation; held with x_valid.

Behaviour:
- **Reset** (rst=1 at a clock edge; overrides everything, including mid-evaluation):
  - state=IDLE
  - busy=0, x_valid=0, x=0, err=0
  - beat counter=0, accumulator cleared
- **State machine** IDLE -> COLLECT -> DONE:
  - IDLE: in_ready=0. start -> COLLECT.
  - COLLECT: in_ready = !start. Handshake = in_valid && in_ready. When the accepted beat is number NUM_VARS-1 -> DONE.
  - DONE: in_ready=0; x_valid=1; x and err held. start -> COLLECT.
  - start in COLLECT aborts the current evaluation and restarts: counter and accumulator re-initialised, new mode/bound latched. A beat presented in the same cycle as start is not accepted.
  - On the start edge: x_valid<=0, err<=0, busy<=1, counter<=0, mode and bound latched.
  - Accumulator init: 1 for CONST/NONZERO/LE_BOUND, 0 for PARITY.
- **Masking:** masked = in_data & ((1<<in_width)-1), computed at MAX_W+1 bits so in_width=MAX_W gives an all-ones mask.
- **Per accepted beat**, the accumulator updates as follows:
  - CONST: unchanged (stays 1).
  - NONZERO: acc &= (masked != 0).
  - PARITY: acc ^= ^masked.
  - LE_BOUND: acc &= (masked <= bound), unsigned compare at MAX_W bits.
- **Error conditions** (any one sets sticky err for the evaluation; the beat is still counted):
  - in_idx != counter (out-of-order, duplicate or skipped index)
  - in_width == 0
  - in_width > MAX_W
- **Verdict and latency:**
  - Last beat accepted at edge t -> at edge t the block sets x = acc_final && !err_final, x_valid=1, busy=0. x_valid is visible the cycle after the last handshake.
  - err forces x=0 in every mode.
  - Verdict for the same stream is identical regardless of in_valid gaps.
- **Counter:** counts 0..NUM_VARS-1 and never wraps within an evaluation. Beats offered in IDLE or DONE are not accepted (in_ready=0).
- With no start pulse after reset, the outputs stay at their reset values indefinitely.

Test Plan (NUM_VARS=4, MAX_W=8, WID_W=4, IDX_W=2):
1. **CONST with errors:** start mode=0; beats idx 0..3, width 8, data 0x00 each; idx 1 sent as idx 3 -> x_valid=1 one cycle after 4th handshake, err=1, x=0. Repeat with correct idx -> x=1, err=0.
2. **NONZERO with masking:** start mode=1; data {0x01,0x10,0x80,0x03}, widths {1,5,8,2} -> x=1. Rerun with beat 1 width 4 (0x10 masks to 0) -> x=0, err=0.
3. **PARITY with gaps:** start mode=2; data {0x07,0x01,0x00,0xFF}, width 8 -> total set bits 12 -> x=0. Change beat 1 to 0x03 -> x=1. Insert 3-cycle in_valid gaps -> same results.
4. **LE_BOUND boundary:** start mode=3, bound=0x40; data {0x40,0x00,0x3F,0x40}, width 8 -> x=1. Beat 2 = 0x41 -> x=0. Width 0 on beat 0 -> err=1, x=0.
5. **Restart and reset:**
   - Start mode=1; after 2 beats, pulse start with in_valid=1 in the same cycle -> that beat not accepted; new evaluation needs 4 further beats before x_valid.
   - Assert rst mid-COLLECT -> next cycle busy=0, x_valid=0, x=0, err=0, in_ready=0.
6. **Post-DONE behaviour:** beats offered in DONE -> in_ready=0, x and x_valid unchanged. Beats in IDLE after reset -> in_ready=0, no state change.
